regfile_dump: RTL and testbench



---
 rtl/regfile_dump.sv | 118 +++++++++++
 tb/tb_regfile_dump.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug reader: walks every register-file entry through one synchronous read
// port and streams each word MSB-first as bytes over a valid/ready interface.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   reg_cnt_reg;
    logic [BCNT_W-1:0]   byte_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic                tx_valid_reg;
    logic                busy_reg;
    logic                done_reg;

    // Shift left by one byte lane; the vacated low lane fills with zero.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign shift_next[7:0] = 8'h00;
            end else begin : g_up
                assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    // The address counter doubles as the read address, so it stays stable
    // across ISSUE, CAPTURE and SEND of the current register.
    assign rf_addr  = reg_cnt_reg;
    assign tx_data  = shift_reg[DATA_W-1 -: 8];
    assign tx_valid = tx_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            reg_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        reg_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    shift_reg    <= rf_data;
                    byte_cnt_reg <= '0;
                    tx_valid_reg <= 1'b1;
                    state_reg    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        shift_reg <= shift_next;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            tx_valid_reg <= 1'b0;
                            if (reg_cnt_reg == LAST_REG) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                reg_cnt_reg <= reg_cnt_reg + ADDR_W'(1);
                                state_reg   <= S_ISSUE;
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: default 32x32 instance plus a 4x16 instance,
// each with a registered-read register file model.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, done;
    logic [1:0]  rf_addr2;
    logic [15:0] rf_data2;
    logic [7:0]  tx_data2;
    logic        tx_valid2, tx_ready2, busy2, done2;

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    regfile_dump #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rf_addr(rf_addr2), .rf_data(rf_data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .done(done2)
    );

    logic [31:0] rf  [32];
    logic [15:0] rf2 [4];
    always @(posedge clk) rf_data  <= rf[rf_addr];
    always @(posedge clk) rf_data2 <= rf2[rf_addr2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready pattern: always high, or roughly 30% high for backpressure.
    bit rdy_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // Scoreboard state for the default instance.
    logic [7:0] q[$];
    int         idx = 0, done_cnt = 0, e0 = 0;
    bit         lat_on = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (busy) check("rf_addr", 32'(rf_addr), 32'(idx / 4));
            if (stall_prev) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid) check("busy_while_valid", 32'(busy), 32'd1);
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_byte: got 0x%0h, expected no byte", tx_data);
                end else begin
                    check($sformatf("byte[%0d]", idx), 32'(tx_data), 32'(q.pop_front()));
                end
                idx++;
            end
            stall_prev = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                if (lat_on) check("done_latency", 32'(cyc - e0), 32'd192);
            end
        end
    end

    // Scoreboard state for the small instance.
    logic [7:0] q2[$];
    int         idx2 = 0, done_cnt2 = 0, e02 = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy2) check("rf_addr2", 32'(rf_addr2), 32'(idx2 / 2));
            if (tx_valid2 && tx_ready2) begin
                if (q2.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_byte2: got 0x%0h, expected no byte", tx_data2);
                end else begin
                    check($sformatf("byte2[%0d]", idx2), 32'(tx_data2), 32'(q2.pop_front()));
                end
                idx2++;
            end
            if (done2) begin
                done_cnt2++;
                check("done2_latency", 32'(cyc - e02), 32'd16);
            end
        end
    end

    task automatic fill_expected(input bit mutate);
        logic [31:0] w;
        q.delete();
        idx = 0;
        done_cnt = 0;
        for (int r = 0; r < 32; r++) begin
            w = rf[r];
            if (mutate && r == 20) w = 32'h0BADC0DE;
            for (int b = 3; b >= 0; b--) q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input string name, input bit mode, input bit poke, input bit mutate);
        bit poked = 1'b0, mutated = 1'b0, finished = 1'b0;
        rdy_mode = mode;
        lat_on   = !mode;
        fill_expected(mutate);
        pulse_start();
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (mutate && !mutated && idx >= 10) begin
                rf[1]  = 32'hCAFEF00D;
                rf[20] = 32'h0BADC0DE;
                mutated = 1'b1;
            end
            if (poke && !poked && idx >= 50) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (poke && done) start = 1'b1;
            if (poke && idx > 50 && idx < 128) check("busy_mid_dump", 32'(busy), 32'd1);
            if (done_cnt > 0 && !done) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done, expected done within 5000 cycles", name);
        end
        repeat (6) @(posedge clk);
        #2;
        check({name, "_bytes"}, 32'(idx), 32'd128);
        check({name, "_queue_left"}, 32'(q.size()), 32'd0);
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_valid_after"}, 32'(tx_valid), 32'd0);
        rdy_mode = 1'b0;
        $display("dump %s: %0d bytes, %0d done pulse(s)", name, idx, done_cnt);
    endtask

    task automatic run_reset_mid_dump();
        bit hit = 1'b0;
        rdy_mode = 1'b0;
        lat_on   = 1'b1;
        fill_expected(1'b0);
        pulse_start();
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #2;
            if (idx == 30 && tx_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_reach: got idx %0d, expected to reach reg7 byte2", idx);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        #1;
        reset = 1'b0;
        q.delete();
        $display("reset mid-dump after %0d bytes", idx);
        idx = 0;
        done_cnt = 0;
        run_dump("after_reset", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_small();
        bit finished = 1'b0;
        logic [7:0] exp_bytes[8] = '{8'h01, 8'h23, 8'hAB, 8'hCD, 8'hFF, 8'h00, 8'h5A, 8'h5A};
        q2.delete();
        for (int i = 0; i < 8; i++) q2.push_back(exp_bytes[i]);
        idx2 = 0;
        done_cnt2 = 0;
        @(posedge clk); #2;
        start2 = 1'b1;
        @(posedge clk); #1;
        e02 = cyc;
        #1;
        start2 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            if (done_cnt2 > 0 && !done2) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL small_timeout: got no done2, expected done2 within 200 cycles");
        end
        repeat (3) @(posedge clk);
        #2;
        check("small_bytes", 32'(idx2), 32'd8);
        check("small_done_pulses", 32'(done_cnt2), 32'd1);
        check("small_busy_after", 32'(busy2), 32'd0);
        $display("dump small: %0d bytes, %0d done pulse(s)", idx2, done_cnt2);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        tx_ready  = 1'b1;
        tx_ready2 = 1'b1;
        for (int i = 0; i < 32; i++)
            rf[i] = {8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)};
        rf[0]  = 32'h00000000;
        rf[1]  = 32'hDEADBEEF;
        rf[31] = 32'h12345678;
        rf2[0] = 16'h0123;
        rf2[1] = 16'hABCD;
        rf2[2] = 16'hFF00;
        rf2[3] = 16'h5A5A;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        run_dump("ready_high", 1'b0, 1'b0, 1'b0);
        run_dump("backpressure", 1'b1, 1'b0, 1'b0);
        run_dump("start_poke_mutate", 1'b0, 1'b1, 1'b1);
        run_reset_mid_dump();
        run_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
